// File: rtl/cpu_control_unit.sv
// Multi-cycle control FSM for the 16-bit CPU: fetch/decode/execute sequencing,
// memory handshake, register-file addressing and writeback control.
module cpu_control_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ready,
  input  logic [15:0]       rf_rdata_a,
  input  logic [15:0]       rf_rdata_b,
  output logic [3:0]        rf_raddr_a,
  output logic [3:0]        rf_raddr_b,
  output logic [3:0]        rf_waddr,
  output logic              rf_we,
  output logic [1:0]        rf_wsel,
  output logic [15:0]       imm_out,
  output logic [15:0]       mdr_out,
  output logic [2:0]        alu_op,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_BEQZ = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [15:0]       mdr_q, mdr_d;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] br_off;
  logic              writes_in_exec;

  assign opcode         = ir_q[3:0];
  assign br_off         = ADDR_W'($signed(ir_q[11:4]));
  assign writes_in_exec = !opcode[3] || (opcode == OP_LDI);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_LD, OP_ST: state_d = S_MEM;
          // Offset applies to the pc already advanced past this instruction.
          OP_BEQZ: if (rf_rdata_b == '0) pc_d = pc_q + br_off;
          OP_HALT: state_d = S_HALT;
          default: ;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (opcode == OP_LD) begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    mem_wdata = rf_rdata_b;
    rf_we     = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_FETCH: mem_req = 1'b1;
      S_EXEC:  rf_we   = writes_in_exec;
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = (opcode == OP_ST);
        mem_addr = ADDR_W'(rf_rdata_a);
      end
      S_WB:    rf_we  = 1'b1;
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
    // Strobes are masked combinationally so an in-flight access dies with reset.
    if (reset) begin
      mem_req = 1'b0;
      rf_we   = 1'b0;
      halted  = 1'b0;
    end
  end

  always_comb begin
    rf_wsel = 2'd0;
    if (state_q == S_WB)       rf_wsel = 2'd2;
    else if (opcode == OP_LDI) rf_wsel = 2'd1;
  end

  assign rf_raddr_a = ir_q[11:8];
  assign rf_raddr_b = ir_q[15:12];
  assign rf_waddr   = ir_q[7:4];
  assign imm_out    = {{8{ir_q[15]}}, ir_q[15:8]};
  assign mdr_out    = mdr_q;
  assign alu_op     = ir_q[2:0];
  assign pc_out     = pc_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: memory and register-file stand-ins, vector table,
// directed multi-cycle sequences and randomized programs against an ISA-level model.
module tb_cpu_control_unit;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  sel;
  } ev_t;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] a_val;
    logic [15:0] b_val;
    logic [15:0] ld_data;
    int unsigned cycles;
    logic [15:0] exp_pc;
    logic        has_ld;
    logic        has_st;
    logic        has_rf;
    logic        has_next;
    logic [1:0]  rf_sel;
    logic [15:0] rf_val;
  } vec_t;

  localparam logic [1:0] EV_RD = 2'd0;
  localparam logic [1:0] EV_WR = 2'd1;
  localparam logic [1:0] EV_RF = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] rf_rdata_a, rf_rdata_b;
  logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic        rf_we;
  logic [1:0]  rf_wsel;
  logic [15:0] imm_out, mdr_out, pc_out;
  logic [2:0]  alu_op;
  logic        halted;

  logic [15:0] mem   [0:65535];
  logic [15:0] regs  [0:15];
  logic [15:0] mmem  [0:65535];
  logic [15:0] mregs [0:15];
  ev_t         obs[$];
  ev_t         exp_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned ready_mode = 0;
  logic        prev_wait = 1'b0;
  logic [33:0] prev_bus = '0;
  vec_t        vecs[12];

  cpu_control_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_waddr(rf_waddr),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .imm_out(imm_out), .mdr_out(mdr_out),
    .alu_op(alu_op), .pc_out(pc_out), .halted(halted)
  );

  always #5 clk = ~clk;

  assign mem_rdata  = mem[mem_addr];
  assign rf_rdata_a = regs[rf_raddr_a];
  assign rf_rdata_b = regs[rf_raddr_b];

  // Arbitrary stand-in ALU; only its dependence on alu_op matters here.
  function automatic logic [15:0] tb_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << 1;
      3'd6:    return a >> 1;
      default: return ~a;
    endcase
  endfunction

  function automatic ev_t mk(input logic [1:0] k, input logic [15:0] a, input logic [15:0] d, input logic [1:0] s);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.sel = s;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [15:0] instr, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] ld, input int unsigned cyc, input logic [15:0] pc,
                               input logic hl, input logic hs, input logic hr, input logic hn,
                               input logic [1:0] sel, input logic [15:0] val);
    vec_t v;
    v.instr = instr; v.a_val = a; v.b_val = b; v.ld_data = ld; v.cycles = cyc; v.exp_pc = pc;
    v.has_ld = hl; v.has_st = hs; v.has_rf = hr; v.has_next = hn; v.rf_sel = sel; v.rf_val = val;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory / register-file emulation and bus observation.
  always @(negedge clk) begin
    logic [15:0] v;
    if (reset) begin
      check("reset_quiet", {61'd0, mem_req, rf_we, halted}, 64'd0);
      prev_wait = 1'b0;
    end else begin
      if (prev_wait)
        check("mem_hold", {30'd0, mem_req, mem_we, mem_addr, mem_wdata}, {30'd0, prev_bus});
      if (mem_req && mem_ready) begin
        obs.push_back(mk(mem_we ? EV_WR : EV_RD, mem_addr, mem_we ? mem_wdata : 16'h0, 2'd0));
        if (mem_we) mem[mem_addr] = mem_wdata;
      end
      if (rf_we) begin
        case (rf_wsel)
          2'd0:    v = tb_alu(alu_op, rf_rdata_a, rf_rdata_b);
          2'd1:    v = imm_out;
          2'd2:    v = mdr_out;
          default: v = 16'hDEAD;
        endcase
        obs.push_back(mk(EV_RF, {12'h0, rf_waddr}, v, rf_wsel));
        regs[rf_waddr] = v;
      end
      prev_wait = mem_req && !mem_ready;
      prev_bus  = {mem_req, mem_we, mem_addr, mem_wdata};
    end
  end

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0)      mem_ready = 1'b1;
    else if (ready_mode == 1) mem_ready = ($urandom_range(2) != 0);
  end

  task automatic prep(input logic [15:0] fill);
    reset = 1'b1;
    for (int unsigned i = 0; i < 65536; i++) mem[i] = fill;
    for (int unsigned i = 0; i < 16; i++) regs[i] = 16'h1000 + 16'(i);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_pc", {48'd0, pc_out}, 64'd0);
    check("reset_ir", {41'd0, alu_op, rf_waddr, imm_out}, 64'd0);
    check("reset_mdr", {48'd0, mdr_out}, 64'd0);
    obs.delete();
    reset = 1'b0;
  endtask

  task automatic compare_events(input string name);
    int unsigned n;
    check({name, "_count"}, 64'(obs.size()), 64'(exp_q.size()));
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int unsigned i = 0; i < n; i++) begin
      check($sformatf("%s_ev%0d", name, i), 64'(obs[i]), 64'(exp_q[i]));
      if (obs[i] !== exp_q[i]) break;
    end
  endtask

  task automatic run_vec(input int unsigned idx, input vec_t v);
    int unsigned n;
    prep(16'h000F);
    mem[0] = v.instr;
    regs[v.instr[11:8]]  = v.a_val;
    regs[v.instr[15:12]] = v.b_val;
    if (v.has_ld) mem[v.a_val] = v.ld_data;
    ready_mode = 0;
    mem_ready  = 1'b1;
    do_reset();
    n = 0;
    while (!halted && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("vec%0d_cycles", idx), 64'(n), 64'(v.cycles));
    check($sformatf("vec%0d_pc", idx), {48'd0, pc_out}, {48'd0, v.exp_pc});
    exp_q.delete();
    exp_q.push_back(mk(EV_RD, 16'h0000, 16'h0, 2'd0));
    if (v.has_ld) exp_q.push_back(mk(EV_RD, v.a_val, 16'h0, 2'd0));
    if (v.has_st) exp_q.push_back(mk(EV_WR, v.a_val, v.b_val, 2'd0));
    if (v.has_rf) exp_q.push_back(mk(EV_RF, {12'h0, v.instr[7:4]}, v.rf_val, v.rf_sel));
    if (v.has_next) exp_q.push_back(mk(EV_RD, v.exp_pc - 16'h1, 16'h0, 2'd0));
    compare_events($sformatf("vec%0d", idx));
  endtask

  // ISA-level reference: executes whole instructions and lists the bus/regfile events.
  task automatic model_run(input int unsigned n, output logic halted_m);
    logic [15:0] pc, ir, a, b, v;
    logic [3:0]  op;
    pc = 16'h0000;
    halted_m = 1'b0;
    exp_q.delete();
    for (int unsigned k = 0; k < n && !halted_m; k++) begin
      ir = mmem[pc];
      exp_q.push_back(mk(EV_RD, pc, 16'h0, 2'd0));
      pc = pc + 16'h1;
      op = ir[3:0];
      a  = mregs[ir[11:8]];
      b  = mregs[ir[15:12]];
      if (op < 4'h8) begin
        v = tb_alu(op[2:0], a, b);
        exp_q.push_back(mk(EV_RF, {12'h0, ir[7:4]}, v, 2'd0));
        mregs[ir[7:4]] = v;
      end else if (op == 4'h8) begin
        v = {{8{ir[15]}}, ir[15:8]};
        exp_q.push_back(mk(EV_RF, {12'h0, ir[7:4]}, v, 2'd1));
        mregs[ir[7:4]] = v;
      end else if (op == 4'h9) begin
        exp_q.push_back(mk(EV_RD, a, 16'h0, 2'd0));
        v = mmem[a];
        exp_q.push_back(mk(EV_RF, {12'h0, ir[7:4]}, v, 2'd2));
        mregs[ir[7:4]] = v;
      end else if (op == 4'hA) begin
        exp_q.push_back(mk(EV_WR, a, b, 2'd0));
        mmem[a] = b;
      end else if (op == 4'hB) begin
        if (b == 16'h0) pc = pc + {{8{ir[11]}}, ir[11:4]};
      end else if (op == 4'hF) begin
        halted_m = 1'b1;
      end
    end
  endtask

  task automatic run_random(input int unsigned r, input int unsigned n);
    logic        halted_m;
    int unsigned cyc;
    reset = 1'b1;
    for (int unsigned i = 0; i < 65536; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i][3:0] == 4'hF && $urandom_range(7) != 0) mem[i][3:0] = 4'hC;
      mmem[i] = mem[i];
    end
    for (int unsigned i = 0; i < 16; i++) begin
      regs[i]  = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
      mregs[i] = regs[i];
    end
    model_run(n, halted_m);
    ready_mode = 1;
    do_reset();
    cyc = 0;
    while (obs.size() < exp_q.size() && cyc < 60 * n + 200) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check($sformatf("rand%0d_complete", r), 64'(obs.size() >= exp_q.size()), 64'd1);
    for (int unsigned i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      check($sformatf("rand%0d_ev%0d", r, i), 64'(obs[i]), 64'(exp_q[i]));
      if (obs[i] !== exp_q[i]) break;
    end
    if (halted_m) begin
      repeat (5) @(posedge clk);
      #1;
      check($sformatf("rand%0d_halted", r), {63'd0, halted}, 64'd1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    int unsigned wr_cnt;
    reset     = 1'b1;
    mem_ready = 1'b1;

    vecs[0]  = mkv(16'h2130, 16'h0005, 16'h0007, 16'h0, 6, 16'h0002, 0, 0, 1, 1, 2'd0, tb_alu(3'd0, 16'h0005, 16'h0007));
    vecs[1]  = mkv(16'h5417, 16'h00F0, 16'h0001, 16'h0, 6, 16'h0002, 0, 0, 1, 1, 2'd0, tb_alu(3'd7, 16'h00F0, 16'h0001));
    vecs[2]  = mkv(16'h3211, 16'h0003, 16'h0005, 16'h0, 6, 16'h0002, 0, 0, 1, 1, 2'd0, tb_alu(3'd1, 16'h0003, 16'h0005));
    vecs[3]  = mkv(16'hFE58, 16'h1111, 16'h2222, 16'h0, 6, 16'h0002, 0, 0, 1, 1, 2'd1, 16'hFFFE);
    vecs[4]  = mkv(16'h7F68, 16'h1111, 16'h2222, 16'h0, 6, 16'h0002, 0, 0, 1, 1, 2'd1, 16'h007F);
    vecs[5]  = mkv(16'h0349, 16'h0040, 16'h0000, 16'hBEEF, 8, 16'h0002, 1, 0, 1, 1, 2'd2, 16'hBEEF);
    vecs[6]  = mkv(16'h210A, 16'h0080, 16'h1234, 16'h0, 7, 16'h0002, 0, 1, 0, 1, 2'd0, 16'h0);
    vecs[7]  = mkv(16'h203B, 16'h5555, 16'h0000, 16'h0, 6, 16'h0005, 0, 0, 0, 1, 2'd0, 16'h0);
    vecs[8]  = mkv(16'h203B, 16'h5555, 16'h0001, 16'h0, 6, 16'h0002, 0, 0, 0, 1, 2'd0, 16'h0);
    vecs[9]  = mkv(16'h280B, 16'h5555, 16'h0000, 16'h0, 6, 16'hFF82, 0, 0, 0, 1, 2'd0, 16'h0);
    vecs[10] = mkv(16'h000D, 16'h0000, 16'h0000, 16'h0, 6, 16'h0002, 0, 0, 0, 1, 2'd0, 16'h0);
    vecs[11] = mkv(16'h000F, 16'h0000, 16'h0000, 16'h0, 3, 16'h0001, 0, 0, 0, 0, 2'd0, 16'h0);

    for (int unsigned i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // ADD: per-cycle view of FETCH, DECODE, EXEC.
    prep(16'h000F);
    mem[0] = 16'h2130;
    ready_mode = 0; mem_ready = 1'b1;
    do_reset();
    @(negedge clk);
    check("add_fetch", {45'd0, mem_req, mem_we, mem_addr, rf_we}, {45'd0, 1'b1, 1'b0, 16'h0000, 1'b0});
    @(negedge clk);
    check("add_decode", {46'd0, mem_req, rf_we, pc_out}, {46'd0, 1'b0, 1'b0, 16'h0001});
    @(negedge clk);
    check("add_exec", {35'd0, rf_we, rf_waddr, rf_raddr_a, rf_raddr_b, alu_op, rf_wsel, pc_out},
          {35'd0, 1'b1, 4'd3, 4'd1, 4'd2, 3'd0, 2'd0, 16'h0001});

    // LD with three wait cycles in MEM.
    prep(16'h000F);
    mem[0] = 16'h0349; regs[3] = 16'h0040; mem[16'h0040] = 16'hBEEF;
    ready_mode = 2; mem_ready = 1'b1;
    do_reset();
    @(posedge clk); #1 mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("ld_wait%0d", k), {45'd0, mem_req, mem_we, mem_addr, rf_we}, {45'd0, 1'b1, 1'b0, 16'h0040, 1'b0});
    end
    @(posedge clk); #1 mem_ready = 1'b1;
    @(negedge clk);
    check("ld_accept_no_we", {63'd0, rf_we}, 64'd0);
    @(negedge clk);
    check("ld_wb", {41'd0, mdr_out, rf_we, rf_wsel, rf_waddr}, {41'd0, 16'hBEEF, 1'b1, 2'd2, 4'd4});
    ready_mode = 0;

    // Branch to 0xFFFF, then pc wraps to 0x0000.
    prep(16'h000F);
    mem[0] = 16'h0FEB; mem[16'hFFFF] = 16'h000C; regs[0] = 16'h0000;
    ready_mode = 0; mem_ready = 1'b1;
    do_reset();
    n = 0;
    while (obs.size() < 3 && n < 30) begin
      @(posedge clk);
      n++;
    end
    check("wrap_fetches_seen", 64'(obs.size() >= 3), 64'd1);
    exp_q.delete();
    exp_q.push_back(mk(EV_RD, 16'h0000, 16'h0, 2'd0));
    exp_q.push_back(mk(EV_RD, 16'hFFFF, 16'h0, 2'd0));
    exp_q.push_back(mk(EV_RD, 16'h0000, 16'h0, 2'd0));
    for (int unsigned i = 0; i < 3 && i < obs.size(); i++)
      check($sformatf("wrap_ev%0d", i), 64'(obs[i]), 64'(exp_q[i]));

    // HALT holds off all requests regardless of mem_ready.
    prep(16'h000F);
    ready_mode = 1;
    do_reset();
    n = 0;
    while (!halted && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("halt_reached", {63'd0, halted}, 64'd1);
    for (int unsigned k = 0; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("halt_idle%0d", k), {62'd0, mem_req, halted}, 64'd1);
    end

    // Reset during a stalled store.
    prep(16'h000F);
    mem[0] = 16'h210A; regs[1] = 16'h0080; regs[2] = 16'h1234; mem[16'h0080] = 16'hAAAA;
    ready_mode = 2; mem_ready = 1'b1;
    do_reset();
    @(posedge clk); #1 mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("st_wait", {30'd0, mem_req, mem_we, mem_addr, mem_wdata}, {30'd0, 1'b1, 1'b1, 16'h0080, 16'h1234});
    @(posedge clk); #1;
    reset = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check("st_reset_quiet", {62'd0, mem_req, rf_we}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("st_reset_quiet2", {62'd0, mem_req, rf_we}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("st_restart_fetch", {46'd0, mem_req, mem_we, mem_addr}, {46'd0, 1'b1, 1'b0, 16'h0000});
    wr_cnt = 0;
    foreach (obs[i]) if (obs[i].kind != EV_RD) wr_cnt++;
    check("st_aborted_no_write", {32'd0, 32'(wr_cnt)}, 64'd0);
    check("st_aborted_mem", {48'd0, mem[16'h0080]}, {48'd0, 16'hAAAA});
    ready_mode = 0;

    for (int unsigned r = 0; r < 3; r++) run_random(r, 300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Multi-cycle control FSM for the 16-bit CPU.
- Fetches instructions over a ready/request memory handshake and decodes the register fields that feed the ALU operand ports (bits 11:8 and bits 15:12).
- Drives the 3-bit ALU opcode, register-file addresses and write enable, the writeback select, and the memory load/store sequencing.
- Sits between instruction/data memory and the datapath (register file, ALU, writeback mux).

Parameters:
- ADDR_W, 16, width of pc and mem_addr.
- RESET_PC, 0, pc value after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- mem_req  output  1  memory request, held until accepted.
- mem_we  output  1  1 = store, 0 = read.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  16  store data.
- mem_rdata  input  16  read data, valid when mem_ready=1.
- mem_ready  input  1  memory accepts/completes the request this cycle.
- rf_rdata_a  input  16  register file port A data (register addressed by ir[11:8]).
- rf_rdata_b  input  16  register file port B data (register addressed by ir[15:12]).
- rf_raddr_a  output  4  ir[11:8].
- rf_raddr_b  output  4  ir[15:12].
- rf_waddr  output  4  ir[7:4].
- rf_we  output  1  register write strobe, one cycle.
- rf_wsel  output  2  writeback source: 0 = ALU, 1 = IMM, 2 = MDR.
- imm_out  output  16  sign-extended ir[15:8].
- mdr_out  output  16  latched load data.
- alu_op  output  3  ALU opcode, equal to ir[2:0].
- pc_out  output  ADDR_W  current pc.
- halted  output  1  HALT state indicator.

Behaviour:
- Instruction format: [15:12] rB, [11:8] rA, [7:4] rd, [3:0] opcode.
- Opcodes:
  - 0x0–0x7: ALU op, rd <= ALU(rA, rB), alu_op = opcode[2:0].
  - 0x8: LDI, rd <= sext(ir[15:8]).
  - 0x9: LD, rd <= mem[rA].
  - 0xA: ST, mem[rA] <= rB.
  - 0xB: BEQZ, if rB == 0 then pc <= pc + sext(ir[11:4]).
  - 0xF: HALT.
  - 0xC–0xE: NOP.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. State, pc, ir and mdr are registered. Outputs decode combinationally from state and ir.
- Reset (synchronous):
  - state=FETCH, pc=RESET_PC, ir=0, mdr=0.
  - While reset=1, mem_req=0, rf_we=0 and halted=0.
  - Reset asserted in any state, including mid-handshake, aborts the operation with no register write; the next cycle restarts FETCH.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - Hold until mem_ready=1. On that edge: ir <= mem_rdata, pc <= pc+1 (modulo 2^ADDR_W; 0xFFFF wraps to 0x0000), go to DECODE.
- DECODE: one cycle. Register reads settle. No strobes. Go to EXEC.
- EXEC:
  - ALU op: rf_we=1, rf_wsel=0 → FETCH.
  - LDI: rf_we=1, rf_wsel=1 → FETCH.
  - LD / ST → MEM.
  - BEQZ: pc <= pc + sext(ir[11:4]) if rf_rdata_b == 0, else pc unchanged → FETCH. Branch offset is relative to the already-incremented pc; the sum wraps.
  - NOP → FETCH.
  - HALT → HALT.
- MEM:
  - mem_req=1, mem_addr=rf_rdata_a[ADDR_W-1:0].
  - ST: mem_we=1, mem_wdata=rf_rdata_b. On mem_ready → FETCH.
  - LD: mem_we=0. On mem_ready, mdr <= mem_rdata → WB.
  - mem_req, mem_we, mem_addr and mem_wdata stay stable while mem_ready=0.
- WB: rf_we=1, rf_wsel=2 → FETCH.
- HALT: halted=1, no requests. Only reset exits.
- mem_ready while mem_req=0 is ignored.
- Cycle counts with mem_ready tied high:
  - ALU op / LDI / BEQZ / NOP: 3 cycles.
  - ST: 4 cycles.
  - LD: 5 cycles.
- rf_we is never high outside EXEC or WB.

Test Plan:
- Reset, mem_ready=1, mem[0]=0x2130 (ADD rd=3, rA=1, rB=2) → FETCH/DECODE/EXEC. rf_we=1 in cycle 3 with rf_waddr=3, rf_raddr_a=1, rf_raddr_b=2, alu_op=000, rf_wsel=0. pc_out=1.
- LDI with ir=0xFE58 → imm_out=0xFFFE, rf_waddr=5, rf_wsel=1. rf_we pulses exactly one cycle.
- LD with rA=0x0040, mem[0x40]=0xBEEF, mem_ready delayed 3 cycles → mem_req held with mem_addr=0x0040 stable. Then mdr_out=0xBEEF, and rf_we with rf_wsel=2 occurs one cycle later.
- BEQZ at pc=0x0010, rB=0, offset 0xFE (-2) → next fetch address is 0x000F. With rB=1, next fetch address is 0x0011.
- pc=0xFFFF, NOP fetched → next fetch address is 0x0000. HALT → halted=1, mem_req stays 0 for 20 cycles.
- Reset asserted during a ST MEM wait → no further mem_req during reset, no rf_we. Next cycle after deassert: FETCH at RESET_PC.
